reg_to_uart: RTL and testbench
==============================

REG_TO_UART -- requirements
Module: reg_to_uart

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000: system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 9_600: UART bit rate in bit/s.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8: data bits per frame.
REQ-004 SHALL have port clk, input, 1: system clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port send, input, 1: transmit request; its rising edge triggers a transfer.
REQ-007 SHALL have port data_in, input, PAYLOAD_BITS: word to transmit.
REQ-008 SHALL have port txd_pin, output, 1: UART transmit line, idle high.
REQ-009 SHALL have port busy, output, 1: high while a transfer is in progress.

Function
REQ-010 SHALL register send into send_q every cycle; trigger = send & ~send_q.
REQ-011 SHALL, on a trigger in IDLE, latch data_in, drive txd_pin low and busy high from that same clock edge.
REQ-012 SHALL ignore any trigger while busy is high; no queuing, latched data unchanged.
REQ-013 SHALL use 8N1 framing: start bit 0, PAYLOAD_BITS data bits LSB first, one stop bit 1.
REQ-014 SHALL hold each bit for CYCLES_PER_BIT = CLK_HZ/BIT_RATE cycles (integer division); counter width = clog2(CYCLES_PER_BIT).
REQ-015 SHALL run the FSM IDLE -> START -> DATA (bit index 0..PAYLOAD_BITS-1) -> STOP -> IDLE, each bit period ending when the cycle counter reaches CYCLES_PER_BIT-1.
REQ-016 SHALL deassert busy on the edge that ends the stop bit; a trigger on that same edge is ignored, and the next trigger is accepted from the following cycle.
REQ-017 SHALL keep txd_pin registered with no combinational path from inputs to txd_pin.

Reset
REQ-018 SHALL, with rst high, set state IDLE, txd_pin 1, busy 0, and clear the cycle and bit counters on the next edge, aborting any frame mid-bit.
REQ-019 SHALL reset send_q to 1, so that send held high through reset does not trigger a transfer.

Configuration
REQ-020 SHALL, with macro REG_TO_UART_ASCII_EN defined, send each trigger as four frames: upper-case ASCII hex of the high nibble, then of the low nibble, then 0x0D, then 0x0A; busy stays high across all four, with no idle gap between frames.
REQ-021 SHALL, without REG_TO_UART_ASCII_EN, send exactly one frame carrying the raw latched data_in.
REQ-022 SHALL, with the macro defined, require PAYLOAD_BITS = 8.

Structure
REQ-023 SHALL place the FSM state encoding and the ASCII CR/LF constants in shared package uart_pkg.
REQ-024 SHALL implement serialisation in sub-module uart_tx (byte in, valid/busy handshake, txd out); reg_to_uart holds trigger detection, data latch and the ASCII sequencer.

Verification (bench: CLK_HZ=100_000_000, BIT_RATE=10_000_000, i.e. 10 cycles/bit)
REQ-025 SHALL check: data_in=0xA5, one-cycle send pulse -> txd_pin bits 0,1,0,1,0,0,1,0,1,1, each 10 cycles; busy high exactly 100 cycles.
REQ-026 SHALL check: second send with data_in=0x3C at cycle 40 of the 0xA5 frame -> ignored, only the 0xA5 frame appears, txd_pin idle afterwards.
REQ-027 SHALL check: send held high for 300 cycles -> exactly one frame.
REQ-028 SHALL check: rst pulsed at cycle 45 of a frame while send is held high -> txd_pin 1 and busy 0 from the next edge, and no frame after rst is released.
REQ-029 SHALL check: data_in changed to 0xFF one cycle after the trigger -> the frame still carries the original 0xA5.
REQ-030 SHALL check, with REG_TO_UART_ASCII_EN: data_in=0x7E -> frames 0x37, 0x45, 0x0D, 0x0A back-to-back; busy high 400 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the register-to-UART transmitter: serialiser state
// encoding, line-control characters and small constant helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Upper-case ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1-style serialiser: start bit, PAYLOAD_BITS data bits LSB first, stop bit.
// A new frame may be chained on the edge that ends the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BIT_RATE     = 9_600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic [PAYLOAD_BITS-1:0] data,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    txd
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CNT_W          = safe_clog2(CYCLES_PER_BIT);
  localparam int IDX_W          = safe_clog2(PAYLOAD_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] bit_idx, bit_idx_n;
  logic             txd_n, busy_n;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      txd     <= txd_n;
      busy    <= busy_n;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    txd_n      = txd;
    busy_n     = busy;
    frame_done = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        txd_n     = 1'b1;
        busy_n    = 1'b0;
        if (valid) begin
          state_n = ST_START;
          txd_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end

      // Data is not needed until the start bit ends, so the caller may load
      // its holding register on the same edge that starts the frame.
      ST_START: begin
        if (bit_end) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = ST_DATA;
          txd_n     = data[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == IDX_LAST) begin
            state_n = ST_STOP;
            txd_n   = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            txd_n     = data[bit_idx_n];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          cnt_n      = '0;
          frame_done = 1'b1;
          if (valid) begin
            state_n = ST_START;
            txd_n   = 1'b0;
          end else begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
        txd_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_to_uart.sv
// Sends a register value over UART on each rising edge of send.
// Define REG_TO_UART_ASCII_EN to send the value as two hex digits plus CR/LF.
module reg_to_uart
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BIT_RATE     = 9_600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    send,
  input  logic [PAYLOAD_BITS-1:0] data_in,
  output logic                    txd_pin,
  output logic                    busy
);

`ifdef REG_TO_UART_ASCII_EN
  localparam logic [1:0] LAST_FRAME = 2'd3;
`else
  localparam logic [1:0] LAST_FRAME = 2'd0;
`endif

  logic                    send_q;
  logic                    trigger, start, chain, tx_valid;
  logic                    tx_busy, frame_done;
  logic [PAYLOAD_BITS-1:0] data_q, tx_data;
  logic [1:0]              frame_idx;

  assign trigger  = send & ~send_q;
  assign start    = trigger & ~tx_busy;
  assign chain    = frame_done & (frame_idx != LAST_FRAME);
  assign tx_valid = start | chain;
  assign busy     = tx_busy;

  // send_q resets high so a send level held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      send_q    <= 1'b1;
      frame_idx <= '0;
    end else begin
      send_q <= send;
      if (start) begin
        frame_idx <= '0;
      end else if (chain) begin
        frame_idx <= frame_idx + 2'd1;
      end
    end
  end

  // NOTE: the data holding register has no reset; it is only read while a
  // frame is active, and that frame always loads it first.
  always_ff @(posedge clk) begin
    if (start) begin
      data_q <= data_in;
    end
  end

`ifdef REG_TO_UART_ASCII_EN
  if (PAYLOAD_BITS != 8) begin : g_bad_width
    $error("reg_to_uart: ASCII mode requires PAYLOAD_BITS == 8");
  end

  always_comb begin
    tx_data = ASCII_LF;
    case (frame_idx)
      2'd0:    tx_data = hex_ascii(data_q[7:4]);
      2'd1:    tx_data = hex_ascii(data_q[3:0]);
      2'd2:    tx_data = ASCII_CR;
      default: tx_data = ASCII_LF;
    endcase
  end
`else
  assign tx_data = data_q;
`endif

  uart_tx #(
    .CLK_HZ      (CLK_HZ),
    .BIT_RATE    (BIT_RATE),
    .PAYLOAD_BITS(PAYLOAD_BITS)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .valid     (tx_valid),
    .data      (tx_data),
    .busy      (tx_busy),
    .frame_done(frame_done),
    .txd       (txd_pin)
  );

endmodule

// File: tb/tb_reg_to_uart.sv
// Self-checking bench for reg_to_uart at 10 clock cycles per bit; expected line
// waveforms come from a frame-level model. Honours REG_TO_UART_ASCII_EN.
module tb_reg_to_uart;

  localparam int CLK_HZ    = 100_000_000;
  localparam int BIT_RATE  = 10_000_000;
  localparam int CPB       = CLK_HZ / BIT_RATE;
  localparam int FRAME_CYC = 10 * CPB;
`ifdef REG_TO_UART_ASCII_EN
  localparam int NF = 4;
`else
  localparam int NF = 1;
`endif
  localparam int BUSY_CYC = NF * FRAME_CYC;

  logic       clk = 1'b0;
  logic       rst, send;
  logic [7:0] data_in;
  logic       txd_pin, busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_frames [4];

  typedef struct {
    string      name;
    logic [7:0] data;
    int         hold;       // cycles send is held high from the trigger
    int         poke_at;    // cycle at which data_in changes (-1: never)
    logic [7:0] poke_data;
    bit         poke_send;  // also pulse send at poke_at
    int         rst_at;     // cycle at which rst is pulsed (-1: never)
    int         exp_busy;   // expected cycles of busy/frame before idle
  } vec_t;

  vec_t tbl[$];

  reg_to_uart #(
    .CLK_HZ      (CLK_HZ),
    .BIT_RATE    (BIT_RATE),
    .PAYLOAD_BITS(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .send   (send),
    .data_in(data_in),
    .txd_pin(txd_pin),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] hex_char(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  task automatic set_model(input logic [7:0] d);
`ifdef REG_TO_UART_ASCII_EN
    exp_frames[0] = hex_char(int'(d) / 16);
    exp_frames[1] = hex_char(int'(d) % 16);
    exp_frames[2] = 8'd13;
    exp_frames[3] = 8'd10;
`else
    exp_frames[0] = d;
    exp_frames[1] = 8'hFF;
    exp_frames[2] = 8'hFF;
    exp_frames[3] = 8'hFF;
`endif
  endtask

  // Line level k cycles after the triggering edge of an uninterrupted transfer.
  function automatic logic model_txd(input int k);
    int f, b;
    logic [7:0] fr;
    f = k / FRAME_CYC;
    b = (k % FRAME_CYC) / CPB;
    if (f >= NF) return 1'b1;
    fr = exp_frames[f];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return fr[b-1];
  endfunction

  task automatic drive_window(input vec_t v, input int win);
    for (int c = 0; c < win; c++) begin
      rst     = (c == v.rst_at);
      send    = (c < v.hold) || (v.poke_send && c == v.poke_at);
      data_in = (v.poke_at >= 0 && c >= v.poke_at) ? v.poke_data : v.data;
      @(posedge clk);
      #1;
    end
    rst  = 1'b0;
    send = 1'b0;
  endtask

  task automatic check_window(input vec_t v, input int win);
    int   bad_t, bad_b, first_t, first_b;
    logic e_busy, e_txd;
    bad_t = 0; bad_b = 0; first_t = -1; first_b = -1;
    @(posedge clk);
    for (int k = 0; k < win; k++) begin
      @(negedge clk);
      e_busy = (k < v.exp_busy);
      e_txd  = e_busy ? model_txd(k) : 1'b1;
      if (txd_pin !== e_txd) begin
        bad_t++;
        if (first_t < 0) first_t = k;
      end
      if (busy !== e_busy) begin
        bad_b++;
        if (first_b < 0) first_b = k;
      end
    end
    check($sformatf("%s txd bad cycles (first at %0d)", v.name, first_t), bad_t, 0);
    check($sformatf("%s busy bad cycles (first at %0d)", v.name, first_b), bad_b, 0);
  endtask

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  initial begin
    int   bad, win;
    vec_t r;

    // Reset with send held high: idle line, and no transfer once released.
    rst = 1'b1; send = 1'b1; data_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset txd_pin", txd_pin, 1);
    check("reset busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || txd_pin !== 1'b1) bad++;
    end
    check("send held through reset: active cycles", bad, 0);
    @(posedge clk); #1;
    send = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    tbl.push_back('{"a5_pulse",          8'hA5, 1,   -1,       8'h00, 1'b0, -1, BUSY_CYC});
    tbl.push_back('{"busy_ignores_send", 8'hA5, 1,   40,       8'h3C, 1'b1, -1, BUSY_CYC});
    tbl.push_back('{"send_held_300",     8'hA5, 300, -1,       8'h00, 1'b0, -1, BUSY_CYC});
    tbl.push_back('{"rst_mid_frame",     8'hA5, 250, -1,       8'h00, 1'b0, 45, 45});
    tbl.push_back('{"data_change",       8'hA5, 1,   1,        8'hFF, 1'b0, -1, BUSY_CYC});
    tbl.push_back('{"send_on_stop_edge", 8'h00, 1,   BUSY_CYC, 8'h00, 1'b1, -1, BUSY_CYC});
    tbl.push_back('{"all_ones",          8'hFF, 1,   -1,       8'h00, 1'b0, -1, BUSY_CYC});
    tbl.push_back('{"x7e",               8'h7E, 1,   -1,       8'h00, 1'b0, -1, BUSY_CYC});
    for (int i = 0; i < 8; i++) begin
      r.name      = $sformatf("random%0d", i);
      r.data      = 8'($urandom);
      r.hold      = int'($urandom_range(1, 150));
      r.poke_at   = int'($urandom_range(1, BUSY_CYC));
      r.poke_data = 8'($urandom);
      r.poke_send = 1'($urandom);
      r.rst_at    = -1;
      r.exp_busy  = BUSY_CYC;
      tbl.push_back(r);
    end

    foreach (tbl[i]) begin
      set_model(tbl[i].data);
      win = max3(BUSY_CYC, tbl[i].hold, tbl[i].poke_at + 1) + 40;
      fork
        drive_window(tbl[i], win);
        check_window(tbl[i], win);
      join
    end

    // Trigger one cycle after the stop bit ends must be accepted.
    @(posedge clk); #1;
    data_in = 8'h81;
    for (int c = 0; c <= BUSY_CYC + 1; c++) begin
      send = (c == 0) || (c == BUSY_CYC + 1);
      @(posedge clk); #1;
      if (c == BUSY_CYC) check("busy low after stop edge", busy, 0);
    end
    check("retrigger busy", busy, 1);
    check("retrigger start bit", txd_pin, 0);
    send = 1'b0;
    repeat (BUSY_CYC + 20) @(posedge clk);
    #1;
    check("idle after retrigger busy", busy, 0);
    check("idle after retrigger txd", txd_pin, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
